// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian words from a UART byte stream into instruction memory and holds the CPU in reset while loading
module imem_loader #(
  parameter int ISA_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ISA_WIDTH-1:0]  imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  error
);
  localparam int BPW = ISA_WIDTH / 8;
  localparam int BCW = $clog2(BPW + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] LAST = BCW'(BPW - 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                r_state;
  logic [BCW-1:0]        r_bcnt;
  logic [ISA_WIDTH-1:0]  r_asm;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [TW-1:0]         r_tmo;
  logic                  r_we, r_hold, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ISA_WIDTH-1:0]  r_wdata;
  logic [ADDR_WIDTH:0]   r_wcnt;
  logic                  w_full;
  logic [ISA_WIDTH-1:0]  w_word;
  assign w_full = r_issued[ADDR_WIDTH];
  assign w_word = {r_asm[ISA_WIDTH-9:0], rx_data};
  // r_issued counts words handed to memory; word_count follows one cycle later, after the write
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bcnt   <= '0;
      r_asm    <= '0;
      r_issued <= '0;
      r_tmo    <= '0;
      r_we     <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wcnt   <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (r_we) r_wcnt <= r_wcnt + 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_state  <= LOAD;
          r_hold   <= 1'b1;
          r_wcnt   <= '0;
          r_err    <= 1'b0;
          r_issued <= '0;
          r_bcnt   <= '0;
          r_tmo    <= '0;
        end
        LOAD: if (rx_valid) begin
          r_tmo <= '0;
          if (w_full) r_err <= 1'b1;
          else begin
            r_asm  <= w_word;
            r_bcnt <= (r_bcnt == LAST) ? '0 : r_bcnt + 1'b1;
            if (r_bcnt == LAST) begin
              r_we     <= 1'b1;
              r_addr   <= r_issued[ADDR_WIDTH-1:0];
              r_wdata  <= w_word;
              r_issued <= r_issued + 1'b1;
            end
          end
        end else if (r_tmo == TMAX) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_hold  <= 1'b0;
          if (r_bcnt != '0) r_err <= 1'b1;
        end else r_tmo <= r_tmo + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign word_count = r_wcnt;
  assign error      = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a scoreboard of expected memory writes and end-of-load results
module tb_imem_loader;
  localparam int AW = 2;
  localparam int TO = 16;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          error;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [AW+31:0] wr_q[$];
  logic [AW+1:0]  dn_q[$];

  imem_loader #(.ISA_WIDTH(32), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .word_count(word_count), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every write and every load_done pulse is matched against the scoreboard
  always @(negedge clock) begin
    if (imem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", {1'b1, imem_addr, imem_wdata}, '0);
      else chk("write", {imem_addr, imem_wdata}, wr_q.pop_front());
    end
    if (load_done) begin
      done_cnt++;
      chk("hold_low_at_done", cpu_hold, 0);
      if (dn_q.size() == 0) chk("unexpected_done", {1'b1, word_count, error}, '0);
      else chk("done_count_error", {word_count, error}, dn_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_after_start", cpu_hold, 1);
  endtask

  task automatic wait_done();
    int c = done_cnt;
    int n = 0;
    while (done_cnt == c && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == c) chk("done_timeout", 0, 1);
    repeat (2) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  initial begin
    logic [7:0] b5[8] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h23, 8'h45, 8'h67};
    int n;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, load_done, word_count, error}, '0);
    send_byte(8'h55);
    repeat (3) tick();
    chk("idle_ignores_bytes_wc", word_count, 0);
    // two full words, clean timeout
    pulse_start();
    wr_q.push_back({2'd0, 32'h0000_0001});
    wr_q.push_back({2'd1, 32'hDEAD_BEEF});
    dn_q.push_back({3'd2, 1'b0});
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    chk("hold_during_load", cpu_hold, 1);
    wait_done();
    chk("wc_held_idle", word_count, 2);
    chk("hold_idle", cpu_hold, 0);
    // partial trailing word
    pulse_start();
    chk("wc_cleared_on_start", word_count, 0);
    wr_q.push_back({2'd0, 32'h1234_5678});
    dn_q.push_back({3'd1, 1'b1});
    send_word(32'h1234_5678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_done();
    chk("err_held_idle", error, 1);
    // overflow: 5 words into a 4-word memory
    pulse_start();
    chk("err_cleared_on_start", error, 0);
    wr_q.push_back({2'd0, 32'h0001_0203});
    wr_q.push_back({2'd1, 32'h0405_0607});
    wr_q.push_back({2'd2, 32'h0809_0A0B});
    wr_q.push_back({2'd3, 32'h0C0D_0E0F});
    dn_q.push_back({3'd4, 1'b1});
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    wait_done();
    // reset mid-load
    pulse_start();
    wr_q.push_back({2'd0, 32'h1122_3344});
    send_word(32'h1122_3344);
    send_byte(8'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_midload_outputs", {imem_we, imem_addr, imem_wdata, cpu_hold, load_done, word_count, error}, '0);
    send_word(32'h9999_9999);
    repeat (4) tick();
    chk("no_load_after_reset", cpu_hold, 0);
    // back-to-back strobes with stray starts
    pulse_start();
    wr_q.push_back({2'd0, 32'hCAFE_BABE});
    wr_q.push_back({2'd1, 32'h0123_4567});
    dn_q.push_back({3'd2, 1'b0});
    for (int i = 0; i < 8; i++) begin
      rx_data = b5[i];
      rx_valid = 1'b1;
      start = (i == 2 || i == 5);
      tick();
    end
    rx_valid = 1'b0;
    start = 1'b0;
    tick();
    chk("wc_not_cleared_by_start", word_count, 2);
    wait_done();
    // empty load: load_done exactly TO cycles after start
    pulse_start();
    dn_q.push_back({3'd0, 1'b0});
    n = 0;
    while (!load_done && n < 200) begin
      tick();
      n++;
    end
    chk("empty_load_latency", n, TO);
    repeat (3) tick();
    chk("writes_pending", wr_q.size(), 0);
    chk("dones_pending", dn_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
